// File: rtl/mcpu_bus_pkg.sv
// Shared types and helpers for the CPU memory/IO bus unit: FSM state encoding,
// access size codes and the lane-index width function.
package mcpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } bus_state_t;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    // Ceiling log2; used as clog2(DATA_W/8) to size the byte-lane index.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mcpu_lane_align.sv
// Byte-lane steering for the bus unit (purely combinational): byte enables and
// replicated write data on the way out, lane extraction plus sign/zero extension on the way in.
module mcpu_lane_align
    import mcpu_bus_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 2
) (
    input  logic [1:0]          size,
    input  logic [LANE_W-1:0]   offset,
    input  logic                sign_ext,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata_bus,
    output logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   wdata_rep,
    output logic [DATA_W-1:0]   rdata_ext
);

    localparam int NB = DATA_W / 8;

    logic [3:0]        nbytes;
    logic [DATA_W-1:0] shifted;
    logic              sign_bit;

    assign nbytes  = 4'd1 << size;
    assign shifted = rdata_bus >> {offset, 3'b000};

    always_comb begin
        be        = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        sign_bit  = 1'b0;
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= int'(offset)) && (i < int'(offset) + int'(nbytes));
            // lane i carries byte (i mod access size) so any aligned lane sees its own byte
            wdata_rep[8*i +: 8] = wdata[8*(i % int'(nbytes)) +: 8];
            if (i == int'(nbytes) - 1) sign_bit = shifted[8*i+7];
        end
        for (int b = 0; b < DATA_W; b++) begin
            rdata_ext[b] = (b < 8 * int'(nbytes)) ? shifted[b] : (sign_ext & sign_bit);
        end
    end

endmodule

// File: rtl/mcpu_bus_unit.sv
// Memory/IO access unit between the CPU control FSM and the external bus: one request,
// sub-word lanes, alignment check, optional bus timeout when MCPU_BUS_TIMEOUT_EN is defined.
module mcpu_bus_unit
    import mcpu_bus_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic                resp_err,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                CPU_MIO,
    output logic                mem_w,
    output logic [ADDR_W-1:0]   Addr_out,
    output logic [DATA_W-1:0]   Data_out,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic [DATA_W-1:0]   Data_in,
    input  logic                MIO_ready
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = clog2(NB);

    if (!(DATA_W == 32 || DATA_W == 64) || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("mcpu_bus_unit: DATA_W must be 32 or 64 and TIMEOUT_CYC at least 1");
    end

    bus_state_t        state;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [LANE_W-1:0] off_q;

    logic [1:0]        al_size;
    logic              al_sign;
    logic [LANE_W-1:0] al_off;
    logic [NB-1:0]     al_be;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;

    logic [2:0]        align_mask;
    logic              bad_req;
    logic              timed_out;

    always_comb begin
        case (req_size)
            SZ_BYTE:  align_mask = 3'b000;
            SZ_HALF:  align_mask = 3'b001;
            SZ_WORD:  align_mask = 3'b011;
            SZ_DWORD: align_mask = 3'b111;
        endcase
    end

    assign bad_req = ((req_addr[2:0] & align_mask) != 3'b000) || (int'(req_size) > LANE_W);

    // In IDLE the aligner builds the write lanes from the live request; in BUS it
    // decodes Data_in with the attributes latched at acceptance.
    assign al_size = (state == IDLE) ? req_size : size_q;
    assign al_sign = (state == IDLE) ? req_signed : sign_q;
    assign al_off  = (state == IDLE) ? req_addr[LANE_W-1:0] : off_q;

    mcpu_lane_align #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_align (
        .size      (al_size),
        .offset    (al_off),
        .sign_ext  (al_sign),
        .wdata     (req_wdata),
        .rdata_bus (Data_in),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

`ifdef MCPU_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              wait_cnt <= '0;
        else if (state != BUS)  wait_cnt <= '0;
        else                    wait_cnt <= wait_cnt + 1'b1;
    end

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            CPU_MIO    <= 1'b0;
            mem_w      <= 1'b0;
            Addr_out   <= '0;
            Data_out   <= '0;
            bus_be     <= '0;
            size_q     <= SZ_BYTE;
            sign_q     <= 1'b0;
            off_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (bad_req) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state    <= BUS;
                            CPU_MIO  <= 1'b1;
                            mem_w    <= req_we;
                            Addr_out <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                            Data_out <= al_wdata;
                            bus_be   <= al_be;
                            size_q   <= req_size;
                            sign_q   <= req_signed;
                            off_q    <= req_addr[LANE_W-1:0];
                        end
                    end
                end
                BUS: begin
                    // a completion in the final allowed cycle beats the timeout
                    if (MIO_ready || timed_out) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= ~MIO_ready;
                        resp_rdata <= MIO_ready ? al_rdata : '0;
                        CPU_MIO    <= 1'b0;
                        mem_w      <= 1'b0;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    CPU_MIO    <= 1'b0;
                    mem_w      <= 1'b0;
                end
            endcase
        end
    end

endmodule
